// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan with frame-aligned (tear-free) word promotion.
// Outputs are registered from next-cycle state, so they always match cnt/idx/state.
module seg_scan_ctrl #(
  parameter int         NDIGIT    = 3,
  parameter int         PRESCALE  = 1024,
  parameter int         BLANK     = 16,
  parameter logic [6:0] BLANK_SEG = 7'h7F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  load,
  input  logic [7*NDIGIT-1:0]   seg_in,
  output logic [6:0]            seg_out,
  output logic [NDIGIT-1:0]     an_out,
  output logic                  frame_done,
  output logic                  pend_valid
);

  localparam int SW = 7 * NDIGIT;
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [SW-1:0]   active, active_n;
  logic [SW-1:0]   pend, pend_n;
  logic            pend_valid_n;
  logic            boundary;
  logic            frame_done_n;
  logic [6:0]      seg_n;
  logic [NDIGIT-1:0] an_n;

  always_comb begin
    cnt_n    = '0;
    idx_n    = '0;
    boundary = 1'b0;
    state_n  = ST_IDLE;
    if (ena) begin
      if (state == ST_IDLE) begin
        boundary = 1'b1;
      end else if (cnt == CNT_LAST) begin
        idx_n    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        boundary = (idx == IDX_LAST);
      end else begin
        cnt_n = cnt + 1'b1;
        idx_n = idx;
      end
      state_n = (int'(cnt_n) >= BLANK) ? ST_SHOW : ST_BLANK;
    end

    // A load coinciding with a boundary bypasses pend so the newest word is shown.
    active_n     = active;
    pend_n       = pend;
    pend_valid_n = pend_valid;
    if (boundary) begin
      if (load)
        active_n = seg_in;
      else if (pend_valid)
        active_n = pend;
      pend_valid_n = 1'b0;
    end else if (load) begin
      pend_n       = seg_in;
      pend_valid_n = 1'b1;
    end

    frame_done_n = ena && (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);

    seg_n = BLANK_SEG;
    an_n  = '1;
    if (state_n == ST_SHOW) begin
      for (int d = 0; d < NDIGIT; d++) begin
        if (int'(idx_n) == d) begin
          an_n[d] = 1'b0;
          seg_n   = active_n[7*d +: 7];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      seg_out    <= BLANK_SEG;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      active     <= active_n;
      pend       <= pend_n;
      pend_valid <= pend_valid_n;
      seg_out    <= seg_n;
      an_out     <= an_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed test-plan points plus randomized traffic
// against a frame-position model, run on a BLANK=2 and a BLANK=0 instance.
module tb_seg_scan_ctrl;

  localparam int N  = 3;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int FR = N * P;

  logic        clk = 1'b0;
  logic        rst, ena, load;
  logic [20:0] seg_in;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  an_a, an_b;
  logic        fd_a, fd_b, pv_a, pv_b;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIGIT(N), .PRESCALE(P), .BLANK(B), .BLANK_SEG(7'h7F)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .seg_in(seg_in),
    .seg_out(seg_a), .an_out(an_a), .frame_done(fd_a), .pend_valid(pv_a));

  seg_scan_ctrl #(.NDIGIT(N), .PRESCALE(P), .BLANK(0), .BLANK_SEG(7'h7F)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .seg_in(seg_in),
    .seg_out(seg_b), .an_out(an_b), .frame_done(fd_b), .pend_valid(pv_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: t is the cycle position within the running frame, -1 when idle.
  int          t    = -1;
  logic [20:0] disp = '0;
  logic [20:0] pend = '0;
  logic        pv   = 1'b0;

  task automatic model_edge();
    bit bnd;
    if (!rst) begin
      t = -1; disp = '0; pend = '0; pv = 1'b0;
    end else begin
      bnd = ena && (t < 0 || t == FR - 1);
      t   = ena ? ((t < 0) ? 0 : (t + 1) % FR) : -1;
      if (bnd) begin
        if (load) disp = seg_in;
        else if (pv) disp = pend;
        pv = 1'b0;
      end else if (load) begin
        pend = seg_in;
        pv   = 1'b1;
      end
    end
  endtask

  function automatic logic [2:0] exp_an(input int blank);
    logic [2:0] r = 3'b111;
    if (t >= 0 && (t % P) >= blank) r[t / P] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int blank);
    logic [20:0] sh;
    if (t < 0 || (t % P) < blank) return 7'h7F;
    sh = disp >> (7 * (t / P));
    return sh[6:0];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("an_a",  32'(an_a),  32'(exp_an(B)));
    chk("seg_a", 32'(seg_a), 32'(exp_seg(B)));
    chk("fd_a",  32'(fd_a),  32'(t == FR - 1));
    chk("pv_a",  32'(pv_a),  32'(pv));
    chk("an_b",  32'(an_b),  32'(exp_an(0)));
    chk("seg_b", 32'(seg_b), 32'(exp_seg(0)));
    chk("fd_b",  32'(fd_b),  32'(t == FR - 1));
    chk("pv_b",  32'(pv_b),  32'(pv));
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; load = 1'b1; seg_in = 21'h1FFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_an",  32'(an_a),  32'h7);
      chk("rst_seg", 32'(seg_a), 32'h7F);
      chk("rst_pv",  32'(pv_a),  32'h0);
    end

    // Release with ena held: cycle 0 blank at digit 0; reset-time load discarded.
    rst = 1'b1; load = 1'b0;
    step();
    chk("rel_c0_an", 32'(an_a), 32'h7);
    step();
    step();
    chk("rel_c2_an",  32'(an_a),  32'h6);
    chk("rel_c2_seg", 32'(seg_a), 32'h0);

    // Load in IDLE, then scan a full frame with a mid-frame update.
    ena = 1'b0;
    step();
    load = 1'b1; seg_in = 21'h1_0203;
    step();
    load = 1'b0; ena = 1'b1;
    for (int c = 0; c < 32; c++) begin
      step();
      if (c == 2)  begin chk("c2_an",  32'(an_a), 32'h6); chk("c2_seg",  32'(seg_a), 32'h03); end
      if (c == 10) begin chk("c10_an", 32'(an_a), 32'h5); chk("c10_seg", 32'(seg_a), 32'h04); end
      if (c == 13) chk("c13_pv", 32'(pv_a), 32'h1);
      if (c == 18) begin chk("c18_an", 32'(an_a), 32'h3); chk("c18_seg", 32'(seg_a), 32'h04); end
      if (c == 22) chk("c22_fd", 32'(fd_a), 32'h0);
      if (c == 23) chk("c23_fd", 32'(fd_a), 32'h1);
      if (c == 24) chk("c24_pv", 32'(pv_a), 32'h0);
      if (c == 26) begin chk("c26_an", 32'(an_a), 32'h6); chk("c26_seg", 32'(seg_a), 32'h7F); end
      if (c == 12) begin load = 1'b1; seg_in = 21'h1FFFFF; end
      else load = 1'b0;
    end

    // ena drop mid-slot, then re-enable.
    ena = 1'b0;
    step();
    chk("drop_an", 32'(an_a), 32'h7);
    chk("drop_fd", 32'(fd_a), 32'h0);
    ena = 1'b1;
    step();
    chk("reen_an", 32'(an_a), 32'h7);

    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom % 300) != 0;
      ena    = ($urandom % 50) != 0;
      load   = ($urandom % 8) == 0;
      seg_in = 21'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
